triangle_seq: RTL

Sequenced, handshaked replacement for the combinational triangle calculator. It accepts one triangle job at a time: three sides plus a base and height. A single shared 10-bit adder computes the perimeter, and a single 8-step shift-add multiplier computes the area. It also flags whether the sides form a non-degenerate triangle. The block sits between a job source and a result consumer, both using valid/ready.

---
 rtl/triangle_seq_if.sv | 28 ++
 rtl/triangle_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/triangle_seq_if.sv
// Job/result handshake bundle for triangle_seq: job source on the master side,
// calculator on the slave side.
interface triangle_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [7:0]  c;
   logic [7:0]  base;
   logic [7:0]  height;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  perimeter;
   logic [15:0] area;
   logic        tri_ok;
   logic        busy;
   logic [7:0]  job_count;

   modport master (
      output in_valid, a, b, c, base, height, out_ready,
      input  in_ready, out_valid, perimeter, area, tri_ok, busy, job_count
   );

   modport slave (
      input  in_valid, a, b, c, base, height, out_ready,
      output in_ready, out_valid, perimeter, area, tri_ok, busy, job_count
   );
endinterface

// File: rtl/triangle_seq.sv
// Sequenced triangle calculator: one shared 10-bit adder for the perimeter and
// an 8-step shift-add multiplier for the area, with valid/ready on both sides.
module triangle_seq (
   input  logic           clk,
   input  logic           rst,
   triangle_seq_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_SUM0,
      S_SUM1,
      S_CHK,
      S_MUL,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [7:0]  r_c;
   logic [7:0]  r_base;
   logic [7:0]  r_height;
   logic [9:0]  r_acc;
   logic [15:0] r_prod;
   logic [2:0]  r_cnt;
   logic [9:0]  r_perim;
   logic [15:0] r_area;
   logic        r_ok;
   logic        r_in_ready;
   logic        r_out_valid;
   logic [7:0]  r_jobs;

   logic [9:0]  w_add_a;
   logic [9:0]  w_add_b;
   logic [9:0]  w_sum;
   logic [15:0] w_pp;
   logic [15:0] w_prod_nxt;

   // The single adder sees a+b in SUM0 and acc+c in SUM1.
   always_comb begin
      w_add_a = r_acc;
      w_add_b = {2'b00, r_c};
      if (r_state == S_SUM0) begin
         w_add_a = {2'b00, r_a};
         w_add_b = {2'b00, r_b};
      end
      w_sum      = w_add_a + w_add_b;
      w_pp       = r_height[r_cnt] ? ({8'b0, r_base} << r_cnt) : '0;
      w_prod_nxt = r_prod + w_pp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_base      <= '0;
         r_height    <= '0;
         r_acc       <= '0;
         r_prod      <= '0;
         r_cnt       <= '0;
         r_perim     <= '0;
         r_area      <= '0;
         r_ok        <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_jobs      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a        <= bus.a;
                  r_b        <= bus.b;
                  r_c        <= bus.c;
                  r_base     <= bus.base;
                  r_height   <= bus.height;
                  r_in_ready <= 1'b0;
                  r_state    <= S_SUM0;
               end
            end
            S_SUM0: begin
               r_acc   <= w_sum;
               r_state <= S_SUM1;
            end
            S_SUM1: begin
               r_acc   <= w_sum;
               r_perim <= w_sum;
               r_state <= S_CHK;
            end
            S_CHK: begin
               r_ok    <= ({1'b0, r_a, 1'b0} < r_perim) &&
                          ({1'b0, r_b, 1'b0} < r_perim) &&
                          ({1'b0, r_c, 1'b0} < r_perim);
               r_prod  <= '0;
               r_cnt   <= '0;
               r_state <= S_MUL;
            end
            S_MUL: begin
               r_prod <= w_prod_nxt;
               r_cnt  <= r_cnt + 3'd1;
               if (r_cnt == 3'd7) begin
                  r_area      <= w_prod_nxt >> 1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_jobs      <= r_jobs + 8'd1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b1;
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.busy      = !r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.perimeter = r_perim;
   assign bus.area      = r_area;
   assign bus.tri_ok    = r_ok;
   assign bus.job_count = r_jobs;
endmodule
